booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier sequencer for the MIPS MULT/MULTU path.
- Owns one row of radix-4 Booth partial-product bit cells and retires one Booth digit per cycle into a 2*WIDTH accumulator.
- Provides a start/busy/done handshake to the EX stage, plus a flush input for pipeline cancellation; the result feeds HI/LO write-back.

Parameters:
- WIDTH, 32, operand width; must be even.
- DIGITS, WIDTH/2+1 (localparam), Booth digits per operation over the (WIDTH+2)-bit extended multiplier.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- flush  in  1  cancels an operation in progress.
- busy  out  1  high while in CALC.
- done  out  1  single-cycle pulse; result is valid in that cycle.
- result  out  2*WIDTH  product {HI,LO}; held until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0; accumulator, counter and operand registers cleared.
- States and transitions:
  - IDLE: start=1 -> CALC.
  - CALC: runs for DIGITS cycles, then -> DONE.
  - DONE: done=1 for exactly one cycle; start=1 -> CALC (back-to-back allowed), else -> IDLE.
- Capture on accepted start:
  - X = a extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - Y = b extended the same way, with implicit y[-1]=0.
  - acc=0, digit counter i=0.
- CALC, per cycle (digit i = {Y[2i+1], Y[2i], Y[2i-1]}):
  - Decode: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
  - Row built bitwise from {X[k], X[k-1]} pairs, with X[-1]=0.
  - Negative selections invert bits; the +1 is injected as carry-in at bit 2i of the accumulate.
  - Row is sign-extended to 2*WIDTH; acc <= acc + (row << 2i) + (neg << 2i), modulo 2^(2*WIDTH).
  - i increments; on i==DIGITS-1 the next state is DONE and result <= final acc at the same edge.
- Latency: start in cycle 0 -> busy=1 in cycles 1..DIGITS (1..17) -> done=1 and result valid in cycle DIGITS+1 (18).
- start while busy: ignored; operands and in-flight computation are unaffected.
- flush in CALC: next edge -> IDLE; no done pulse; result keeps its previous value. flush in IDLE/DONE: no effect, except that in DONE it suppresses an accompanying start.
- start and flush in the same IDLE cycle: start wins (the flush has nothing to cancel).
- result changes only at the CALC->DONE edge; done and busy are never high together.
- Reset asserted mid-CALC: immediate return to IDLE, outputs cleared as above; no done pulse.

Decomposition:
- Shared package/header:
  - state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - Booth select one-hot encoding {neg, pos, dneg, dpos};
  - DIGITS derivation.
- One natural sub-module: booth_pp_row, which takes WIDTH+2 bits of X plus a 3-bit digit and outputs a (WIDTH+3)-bit row and a neg flag.
  - Built from per-bit cells instantiated with generate.
  - Purely combinational; the sequencer holds all state, counter and accumulator.

Test Plan:
- MULTU a=3, b=5, start pulse -> busy high 17 cycles, done in cycle 18, result=64'h0000_0000_0000_000F.
- MULT a=32'hFFFF_FFFF (-1), b=32'hFFFF_FFFF -> result=64'h0000_0000_0000_0001; same operands as MULTU -> result=64'hFFFF_FFFE_0000_0001.
- MULT a=32'h8000_0000, b=32'h8000_0000 -> result=64'h4000_0000_0000_0000; MULT a=32'h8000_0000, b=1 -> result=64'hFFFF_FFFF_8000_0000.
- Back-to-back: start held across DONE with new operands 7*6 -> second done exactly 18 cycles after the first, result=42; start pulse during CALC -> ignored, first result unchanged.
- flush asserted in CALC cycle 9 -> IDLE next cycle, no done, result still holds the prior value.
- rst pulsed asynchronously mid-CALC (between clock edges) -> busy/done/result drop to 0 immediately; a following 2*2 operation completes correctly with result=4.
- Random 10k signed/unsigned operand pairs vs. a 64-bit reference multiply, including 0, 1, all-ones and MSB-only corner values.

Source files
------------

// File: rtl/booth_mul_seq_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, digit select encoding, digit count.
package booth_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot Booth selection; all-zero means the digit contributes nothing.
  typedef struct packed {
    logic neg;
    logic pos;
    logic dneg;
    logic dpos;
  } booth_sel_t;

  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

  function automatic booth_sel_t booth_decode(input logic [2:0] digit);
    booth_sel_t sel;
    sel = '0;
    case (digit)
      3'b001, 3'b010: sel.pos  = 1'b1;
      3'b011:         sel.dpos = 1'b1;
      3'b100:         sel.dneg = 1'b1;
      3'b101, 3'b110: sel.neg  = 1'b1;
      default:        sel      = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// EX-stage <-> multiplier bundle: start/flush request side, busy/done/result response side.
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/booth_pp_row.sv
// One radix-4 Booth partial-product row: per-bit cells pick X or 2X and invert for negative digits.
// Purely combinational; the +1 of a negative selection leaves on the neg flag as a carry-in.
module booth_pp_row
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] x,
  input  logic [2:0]       digit,
  output logic [WIDTH+2:0] row,
  output logic             neg
);

  booth_sel_t       sel;
  logic             single;
  logic             dbl;
  logic [WIDTH+3:0] xe;

  assign sel    = booth_decode(digit);
  assign single = sel.pos | sel.neg;
  assign dbl    = sel.dpos | sel.dneg;
  assign neg    = sel.neg | sel.dneg;

  // xe[k+1] is X[k]: X[-1]=0 at the bottom, one sign bit replicated on top.
  assign xe = {x[WIDTH+1], x, 1'b0};

  for (genvar k = 0; k < WIDTH + 3; k++) begin : g_cell
    assign row[k] = ((single & xe[k+1]) | (dbl & xe[k])) ^ neg;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth MULT/MULTU: one digit per cycle, done pulses WIDTH/2+2 cycles after start.
// No backpressure: start is ignored while busy; flush cancels an operation in CALC.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  booth_mul_seq_if.slave bus
);

  localparam int DIGITS = booth_digits(WIDTH);
  localparam int CW     = $clog2(DIGITS);
  localparam int AW     = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH+1:0] x_reg;
  logic [WIDTH+2:0] y_reg;      // {Y, y[-1]}
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_nxt;
  logic [AW-1:0]    result_reg;
  logic [CW-1:0]    cnt;

  logic [CW:0]      shamt;
  logic [2:0]       digit;
  logic [WIDTH+2:0] row;
  logic             neg;
  logic [AW-1:0]    row_ext;
  logic [AW-1:0]    cin;

  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] v, input logic sgn);
    return {{2{sgn & v[WIDTH-1]}}, v};
  endfunction

  assign shamt = {cnt, 1'b0};
  assign digit = y_reg[shamt +: 3];
  assign last  = (cnt == LAST);

  booth_pp_row #(.WIDTH(WIDTH)) u_row (
    .x     (x_reg),
    .digit (digit),
    .row   (row),
    .neg   (neg)
  );

  assign row_ext = {{(AW - WIDTH - 3){row[WIDTH+2]}}, row};
  assign cin     = {{(AW - 1){1'b0}}, neg};
  assign acc_nxt = acc + (row_ext << shamt) + (cin << shamt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          accept    = 1'b1;
        end
      end
      CALC: begin
        if (bus.flush)  state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
      end
      DONE: begin
        // A flush arriving with start in DONE cancels the new request.
        if (bus.start && !bus.flush) begin
          state_nxt = CALC;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CALC);
    bus.done = (state == DONE);
  end

  assign bus.result = result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      result_reg <= '0;
    end else if (accept) begin
      x_reg <= extend(bus.a, bus.is_signed);
      y_reg <= {extend(bus.b, bus.is_signed), 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC && !bus.flush) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last) result_reg <= acc_nxt;
    end
  end

endmodule
